// File: rtl/epc_pkg.sv
// epc_pkg: shared types and constants for the EPC-style peripheral bus master.
// Contents:
//   epc_state_e      - initiator phase encoding IDLE/SETUP/STROBE/HOLD
//   *_ADDR           - peripheral map addresses for the LCD controller and uart
//   epc_max          - integer maximum, used to size the phase counter
package epc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } epc_state_e;

    localparam int LCD_DATA_ADDR    = 'h00;
    localparam int LCD_CONTROL_ADDR = 'h04;
    localparam int UART_DATA_ADDR   = 'h08;
    localparam int UART_STATUS_ADDR = 'h0C;

    function automatic int epc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/epc_phase_counter.sv
// epc_phase_counter: loadable saturating up-counter with terminal-count compare.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears count to 0)
//   i_load     - restart the count at 1 (has priority over i_en)
//   i_en       - increment by one, holding at all-ones instead of wrapping
//   i_term     - terminal value to compare against
//   o_count    - current count
//   o_tc       - high when o_count equals i_term
module epc_phase_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (i_load)
            r_count <= W'(1);
        else if (i_en && r_count != '1)
            r_count <= r_count + W'(1);
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_term);

endmodule

// File: rtl/epc_initiator.sv
// epc_initiator: single-transaction master driving the EPC nCS/Addr/nRD/nWR/RDY bus.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   req_valid/req_ready         - request handshake; ready only while IDLE
//   req_we/req_addr/req_wdata   - request direction, address and write data
//   rsp_valid/rsp_rdata/rsp_err - one-cycle completion with read data and timeout flag
//   nCS/Addr/nRD/nWR/DataOut    - registered bus outputs
//   DataIn/RDY                  - bus read data and peripheral ready
// Build option: EPC_INITIATOR_TIMEOUT_EN compiles in the strobe timeout abort;
// without it the strobe waits for RDY indefinitely and rsp_err stays 0.
module epc_initiator #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8,
    parameter int SETUP_CYC   = 2,
    parameter int STROBE_MIN  = 2,
    parameter int HOLD_CYC    = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              nCS,
    output logic [ADDR_W-1:0] Addr,
    output logic              nRD,
    output logic              nWR,
    output logic [DATA_W-1:0] DataOut,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              RDY
);

    import epc_pkg::*;

    localparam int CNT_W = $clog2(epc_max(epc_max(SETUP_CYC, HOLD_CYC),
                                          epc_max(STROBE_MIN, TIMEOUT_CYC)) + 1);
    localparam logic [CNT_W-1:0] SETUP_T   = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_T  = CNT_W'(STROBE_MIN);
    localparam logic [CNT_W-1:0] HOLD_T    = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_T = CNT_W'(TIMEOUT_CYC);

    epc_state_e        r_state, w_nxt_state;
    logic              r_we, r_ncs, r_nrd, r_nwr, r_err;
    logic              r_rsp_valid, r_rsp_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dout, r_rd, r_rsp_rdata;
    logic              w_load, w_en, w_tc, w_done, w_timeout;
    logic [CNT_W-1:0]  w_term, w_count;

    // One counter serves all three phases; the terminal value follows the phase,
    // and in STROBE it is the timeout limit.
    assign w_term = (r_state == STROBE) ? TIMEOUT_T :
                    (r_state == HOLD)   ? HOLD_T    : SETUP_T;
    assign w_en   = (r_state != IDLE);
    assign w_done = (r_state == STROBE) && (w_count >= STROBE_T) && RDY;
`ifdef EPC_INITIATOR_TIMEOUT_EN
    assign w_timeout = (r_state == STROBE) && w_tc && !w_done;
`else
    assign w_timeout = 1'b0;
`endif

    epc_phase_counter #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_en    (w_en),
        .i_term  (w_term),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_nxt_state = req_valid ? SETUP : IDLE;
                w_load      = req_valid;
            end
            SETUP: begin
                w_nxt_state = w_tc ? STROBE : SETUP;
                w_load      = w_tc;
            end
            STROBE: begin
                w_nxt_state = (w_done || w_timeout) ? HOLD : STROBE;
                w_load      = w_done || w_timeout;
            end
            HOLD: begin
                w_nxt_state = w_tc ? IDLE : HOLD;
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_ncs       <= 1'b1;
            r_nrd       <= 1'b1;
            r_nwr       <= 1'b1;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_dout      <= '0;
            r_rd        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (r_state == IDLE && req_valid) begin
                r_ncs  <= 1'b0;
                r_we   <= req_we;
                r_addr <= req_addr;
                r_err  <= 1'b0;
                if (req_we)
                    r_dout <= req_wdata;
            end
            if (r_state == SETUP && w_tc) begin
                r_nwr <= !r_we;
                r_nrd <= r_we;
            end
            // Writes and aborted reads report zero data.
            if (w_done || w_timeout) begin
                r_nwr <= 1'b1;
                r_nrd <= 1'b1;
                r_err <= w_timeout;
                r_rd  <= (w_done && !r_we) ? DataIn : '0;
            end
            if (r_state == HOLD && w_tc) begin
                r_ncs       <= 1'b1;
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= r_rd;
                r_rsp_err   <= r_err;
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign nCS       = r_ncs;
    assign Addr      = r_addr;
    assign nRD       = r_nrd;
    assign nWR       = r_nwr;
    assign DataOut   = r_dout;

endmodule

// File: tb/tb_epc_initiator.sv
// tb_epc_initiator: scoreboard bench for epc_initiator; requests push expected
// responses and bus shapes, a negedge monitor measures the bus and compares on rsp_valid.
module tb_epc_initiator;

    import epc_pkg::*;

    typedef struct {
        int we;
        int addr;
        int dout;
        int rdata;
        int err;
        int stb;
        int gap;
        int intv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_we;
    logic [5:0] req_addr, Addr;
    logic [7:0] req_wdata, rsp_rdata, DataOut, DataIn;
    logic       rsp_valid, rsp_err, nCS, nRD, nWR, RDY;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rdy_delay = -1;
    int   last_dout = 0;

    epc_initiator #(.TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .nCS       (nCS),
        .Addr      (Addr),
        .nRD       (nRD),
        .nWR       (nWR),
        .DataOut   (DataOut),
        .DataIn    (DataIn),
        .RDY       (RDY)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // RDY stays low for rdy_delay strobe-low cycles, then rises; negative means tied high.
    initial begin
        int scyc;
        scyc = 0;
        RDY  = 1'b1;
        forever begin
            @(negedge clk);
            scyc = (!nRD || !nWR) ? scyc + 1 : 0;
            RDY  = (rdy_delay < 0) || (scyc > rdy_delay);
        end
    end

    initial begin
        int ncs_n, stp_n, wr_n, rd_n, hi_n, gap, a0, d0, unst, both, last_rsp;
        exp_t e;
        ncs_n = 0; stp_n = 0; wr_n = 0; rd_n = 0; hi_n = 0; gap = 0;
        a0 = 0; d0 = 0; unst = 0; both = 0; last_rsp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ncs_n = 0; stp_n = 0; wr_n = 0; rd_n = 0; hi_n = 0; unst = 0; both = 0;
            end else begin
                if (!nCS) begin
                    if (ncs_n == 0) begin
                        a0  = int'(Addr);
                        d0  = int'(DataOut);
                        gap = hi_n;
                    end else if (int'(Addr) != a0 || int'(DataOut) != d0)
                        unst = 1;
                    ncs_n++;
                    if (!nWR) wr_n++;
                    if (!nRD) rd_n++;
                    if (!nWR && !nRD) both = 1;
                    if (nWR && nRD && wr_n == 0 && rd_n == 0) stp_n++;
                    hi_n = 0;
                end else
                    hi_n++;
                if (rsp_valid) begin
                    if (exp_q.size() == 0)
                        chk("unexpected_rsp_valid", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", int'(rsp_rdata), e.rdata);
                        chk("rsp_err", int'(rsp_err), e.err);
                        chk("setup_len", stp_n, 2);
                        chk(e.we != 0 ? "nwr_len" : "nrd_len", e.we != 0 ? wr_n : rd_n, e.stb);
                        chk("idle_strobe_len", e.we != 0 ? rd_n : wr_n, 0);
                        chk("ncs_len", ncs_n, e.stb + 4);
                        chk("addr", a0, e.addr);
                        chk("dataout", d0, e.dout);
                        chk("addr_dout_stable", unst, 0);
                        chk("strobes_overlap", both, 0);
                        if (e.gap >= 0) chk("ncs_high_gap", gap, e.gap);
                        if (e.intv >= 0) chk("rsp_interval", cyc - last_rsp, e.intv);
                    end
                    last_rsp = cyc;
                    ncs_n = 0; stp_n = 0; wr_n = 0; rd_n = 0; unst = 0; both = 0;
                end
            end
        end
    end

    task automatic do_req(input int we, input int addr, input int wdata, input int rdata,
                          input int err, input int stb, input int gap, input int intv);
        exp_t e;
        int n;
        e.we    = we;
        e.addr  = addr;
        e.dout  = (we != 0) ? wdata : last_dout;
        e.rdata = rdata;
        e.err   = err;
        e.stb   = stb;
        e.gap   = gap;
        e.intv  = intv;
        if (we != 0) last_dout = wdata;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_we    = (we != 0);
        req_addr  = 6'(addr);
        req_wdata = 8'(wdata);
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) chk("rsp_wait_expired", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; DataIn = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ncs", int'(nCS), 1);
        chk("rst_nrd", int'(nRD), 1);
        chk("rst_nwr", int'(nWR), 1);
        chk("rst_addr", int'(Addr), 0);
        chk("rst_dataout", int'(DataOut), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_rdata", int'(rsp_rdata), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        rst = 1'b0;
        // Write with RDY tied high, also covering RDY high before the strobe falls.
        do_req(1, LCD_CONTROL_ADDR, 'h38, 0, 0, 2, -1, -1);
        wait_rsp();
        // Read with RDY late by five strobe cycles; DataOut keeps the last write data.
        DataIn = 8'hA5; rdy_delay = 5;
        do_req(0, UART_STATUS_ADDR, 0, 'hA5, 0, 6, -1, -1);
        wait_rsp();
        rdy_delay = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("rsp_rdata_hold", int'(rsp_rdata), 'hA5);
        chk("rsp_err_hold", int'(rsp_err), 0);
        // RDY never arrives in time.
        DataIn = 8'h77;
`ifdef EPC_INITIATOR_TIMEOUT_EN
        rdy_delay = 1000;
        do_req(0, UART_DATA_ADDR, 0, 0, 1, 16, -1, -1);
`else
        rdy_delay = 20;
        do_req(0, UART_DATA_ADDR, 0, 'h77, 0, 21, -1, -1);
`endif
        wait_rsp();
        rdy_delay = -1;
        // Read at minimum strobe width.
        DataIn = 8'h5A;
        do_req(0, LCD_DATA_ADDR, 0, 'h5A, 0, 2, -1, -1);
        wait_rsp();
        // Back-to-back writes with req_valid held.
        do_req(1, LCD_DATA_ADDR, 'h01, 0, 0, 2, -1, -1);
        do_req(1, LCD_DATA_ADDR, 'h02, 0, 0, 2, 1, 7);
        do_req(1, LCD_DATA_ADDR, 'h03, 0, 0, 2, 1, 7);
        wait_rsp();
        // Reset in the second strobe cycle of a write drops the transaction.
        do_req(1, UART_STATUS_ADDR, 'h55, 0, 0, 2, -1, -1);
        for (int i = 0; i < 20 && nWR; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_test_strobe_seen", int'(nWR), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        last_dout = 0;
        @(posedge clk);
        #1;
        chk("mid_rst_ncs", int'(nCS), 1);
        chk("mid_rst_nwr", int'(nWR), 1);
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_req_ready", int'(req_ready), 1);
        chk("post_rst_rsp_valid", int'(rsp_valid), 0);
        do_req(1, UART_DATA_ADDR, 'h99, 0, 0, 2, -1, -1);
        wait_rsp();
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
